// File: rtl/branch_predictor_table.sv
// branch_predictor_table
//   Table of 2^INDEX_BITS saturating counters used as a decode-stage branch
//   predictor. The table is indexed by PC bits (bimodal, HIST_BITS=0) or by
//   PC bits XORed with a non-speculative global history register (gshare,
//   HIST_BITS>0). Lookup is combinational; updates arrive from the MEM stage.
//   Saturating statistics count resolved and mispredicted branches.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   branch_decode_sig       decode-stage instruction is a conditional branch
//   in_addr, offset         decode PC and branch immediate
//   branch_addr             predicted target (in_addr + offset)
//   prediction              predict taken
//   pred_index              table index used for this lookup
//   branch_mem_sig          MEM-stage update strobe
//   actual_branch_decision  resolved outcome (1 = taken)
//   upd_index               pred_index carried with the resolving branch
//   mispredict              MEM-stage misprediction flag
//   stat_branches           resolved-branch count (saturating)
//   stat_mispredicts        mispredicted-branch count (saturating)
module branch_predictor_table #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned HIST_BITS  = 0,
  parameter int unsigned STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  branch_decode_sig,
  input  logic [31:0]           in_addr,
  input  logic [31:0]           offset,
  output logic [31:0]           branch_addr,
  output logic                  prediction,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  branch_mem_sig,
  input  logic                  actual_branch_decision,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  mispredict,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  // Weakly-not-taken: MSB clear, all lower bits set (0 for 1-bit counters).
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [CTR_BITS-1:0]   ctr_table [ENTRIES];
  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [CTR_BITS-1:0]   lookup_ctr;
  logic [CTR_BITS-1:0]   upd_ctr;
  logic                  unused_addr_bits;

  always_comb begin
    pc_idx = in_addr[INDEX_BITS+1:2];
  end

  assign unused_addr_bits = ^{in_addr[31:INDEX_BITS+2], in_addr[1:0]};

  generate
    if (HIST_BITS == 0) begin : g_bimodal
      always_comb begin
        lookup_idx = pc_idx;
      end
    end else begin : g_gshare
      logic [HIST_BITS-1:0] ghr;

      // Truncating {ghr, outcome} keeps the newest HIST_BITS outcomes and
      // stays legal for HIST_BITS == 1.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ghr <= '0;
        end else if (branch_mem_sig) begin
          ghr <= HIST_BITS'({ghr, actual_branch_decision});
        end
      end

      always_comb begin
        lookup_idx = pc_idx ^ INDEX_BITS'(ghr);
      end
    end
  endgenerate

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  always_comb begin
    lookup_ctr  = ctr_table[lookup_idx];
    pred_index  = lookup_idx;
    prediction  = branch_decode_sig & lookup_ctr[CTR_BITS-1];
    branch_addr = in_addr + offset;
    upd_ctr     = ctr_table[upd_index];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_table[i] <= CTR_INIT;
      end
    end else if (branch_mem_sig) begin
      if (actual_branch_decision) begin
        if (upd_ctr != CTR_MAX) begin
          ctr_table[upd_index] <= upd_ctr + 1'b1;
        end
      end else begin
        if (upd_ctr != '0) begin
          ctr_table[upd_index] <= upd_ctr - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (branch_mem_sig) begin
      if (stat_branches != '1) begin
        stat_branches <= stat_branches + 1'b1;
      end
      if (mispredict && (stat_mispredicts != '1)) begin
        stat_mispredicts <= stat_mispredicts + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
module tb_branch_predictor_table;

  typedef struct {
    logic        dec;
    logic [31:0] addr;
    logic [31:0] off;
    logic        mem;
    logic        act;
    logic [3:0]  uidx;
    logic        mis;
    logic        exp_pred;
    logic [3:0]  exp_idx;
  } vec_t;

  typedef struct {
    logic        pred;
    logic [3:0]  idx;
    logic [31:0] addr;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  logic clk;
  logic rst_n;

  // bimodal instance (defaults)
  logic        dec, mem, act, mis;
  logic [31:0] addr, off;
  logic [3:0]  uidx;
  logic [31:0] baddr;
  logic        pred;
  logic [3:0]  pidx;
  logic [31:0] sb, sm;

  // gshare instance
  logic        g_dec, g_mem, g_act, g_mis;
  logic [31:0] g_addr, g_off;
  logic [3:0]  g_uidx;
  logic [31:0] g_baddr;
  logic        g_pred;
  logic [3:0]  g_pidx;
  logic [31:0] g_sb, g_sm;

  // narrow-statistics instance
  logic        s_dec, s_mem, s_act, s_mis;
  logic [31:0] s_addr, s_off;
  logic [3:0]  s_uidx;
  logic [31:0] s_baddr;
  logic        s_pred;
  logic [3:0]  s_pidx;
  logic [3:0]  s_sb, s_sm;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t   sb_q[$];
  vec_t   vecs[19];
  logic [31:0] exp_b, exp_m;

  branch_predictor_table #(.INDEX_BITS(4), .CTR_BITS(2), .HIST_BITS(0), .STAT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .branch_decode_sig(dec), .in_addr(addr), .offset(off),
    .branch_addr(baddr), .prediction(pred), .pred_index(pidx), .branch_mem_sig(mem),
    .actual_branch_decision(act), .upd_index(uidx), .mispredict(mis),
    .stat_branches(sb), .stat_mispredicts(sm)
  );

  branch_predictor_table #(.INDEX_BITS(4), .CTR_BITS(2), .HIST_BITS(4), .STAT_WIDTH(32)) dut_g (
    .clk(clk), .rst_n(rst_n), .branch_decode_sig(g_dec), .in_addr(g_addr), .offset(g_off),
    .branch_addr(g_baddr), .prediction(g_pred), .pred_index(g_pidx), .branch_mem_sig(g_mem),
    .actual_branch_decision(g_act), .upd_index(g_uidx), .mispredict(g_mis),
    .stat_branches(g_sb), .stat_mispredicts(g_sm)
  );

  branch_predictor_table #(.INDEX_BITS(4), .CTR_BITS(2), .HIST_BITS(0), .STAT_WIDTH(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .branch_decode_sig(s_dec), .in_addr(s_addr), .offset(s_off),
    .branch_addr(s_baddr), .prediction(s_pred), .pred_index(s_pidx), .branch_mem_sig(s_mem),
    .actual_branch_decision(s_act), .upd_index(s_uidx), .mispredict(s_mis),
    .stat_branches(s_sb), .stat_mispredicts(s_sm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act_v, exp_v);
    end
  endtask

  initial begin
    exp_t e;
    int   nb, nm;
    logic [3:0] gseq;

    // dec addr off mem act uidx mis | exp_pred exp_idx
    vecs[0]  = '{1'b1, 32'h40,        32'h10,        1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0};
    vecs[1]  = '{1'b1, 32'h14,        32'h100,       1'b1, 1'b1, 4'd5,  1'b1, 1'b0, 4'd5};
    vecs[2]  = '{1'b1, 32'h14,        32'h100,       1'b1, 1'b1, 4'd5,  1'b0, 1'b1, 4'd5};
    vecs[3]  = '{1'b0, 32'h14,        32'h4,         1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd5};
    vecs[4]  = '{1'b1, 32'h14,        32'h8,         1'b1, 1'b1, 4'd5,  1'b0, 1'b1, 4'd5};
    vecs[5]  = '{1'b1, 32'h14,        32'h8,         1'b1, 1'b1, 4'd5,  1'b0, 1'b1, 4'd5};
    vecs[6]  = '{1'b1, 32'h14,        32'h8,         1'b1, 1'b1, 4'd5,  1'b0, 1'b1, 4'd5};
    vecs[7]  = '{1'b1, 32'h14,        32'h8,         1'b1, 1'b0, 4'd5,  1'b1, 1'b1, 4'd5};
    vecs[8]  = '{1'b1, 32'h14,        32'h8,         1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd5};
    vecs[9]  = '{1'b1, 32'h14,        32'h8,         1'b1, 1'b0, 4'd5,  1'b1, 1'b1, 4'd5};
    vecs[10] = '{1'b1, 32'h14,        32'h8,         1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd5};
    vecs[11] = '{1'b1, 32'h0C,        32'h20,        1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 4'd3};
    vecs[12] = '{1'b1, 32'h0C,        32'h20,        1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd3};
    vecs[13] = '{1'b0, 32'hFFFF_FFF0, 32'h20,        1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'hC};
    vecs[14] = '{1'b1, 32'h100,       32'hFFFF_FFF8, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0};
    vecs[15] = '{1'b1, 32'h3C,        32'h0,         1'b1, 1'b0, 4'd15, 1'b0, 1'b0, 4'd15};
    vecs[16] = '{1'b1, 32'h3C,        32'h0,         1'b1, 1'b0, 4'd15, 1'b0, 1'b0, 4'd15};
    vecs[17] = '{1'b1, 32'h3C,        32'h0,         1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 4'd15};
    vecs[18] = '{1'b1, 32'h3C,        32'h0,         1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd15};

    rst_n = 1'b0;
    dec = 1'b0; addr = '0; off = '0; mem = 1'b0; act = 1'b0; uidx = '0; mis = 1'b0;
    g_dec = 1'b0; g_addr = '0; g_off = '0; g_mem = 1'b0; g_act = 1'b0; g_uidx = '0; g_mis = 1'b0;
    s_dec = 1'b0; s_addr = '0; s_off = '0; s_mem = 1'b0; s_act = 1'b0; s_uidx = '0; s_mis = 1'b0;
    exp_b = '0; exp_m = '0;

    repeat (3) @(negedge clk);
    chk("reset_pred", {31'b0, pred}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven bimodal sequence with scoreboard
    for (int i = 0; i < 19; i++) begin
      dec = vecs[i].dec; addr = vecs[i].addr; off = vecs[i].off;
      mem = vecs[i].mem; act = vecs[i].act; uidx = vecs[i].uidx; mis = vecs[i].mis;
      e.pred = vecs[i].exp_pred;
      e.idx  = vecs[i].exp_idx;
      e.addr = vecs[i].addr + vecs[i].off;
      e.sb   = exp_b;
      e.sm   = exp_m;
      sb_q.push_back(e);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 32'h0, 32'h1);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d_pred", i), {31'b0, pred}, {31'b0, e.pred});
        chk($sformatf("v%0d_idx", i), {28'b0, pidx}, {28'b0, e.idx});
        chk($sformatf("v%0d_addr", i), baddr, e.addr);
        chk($sformatf("v%0d_stat_br", i), sb, e.sb);
        chk($sformatf("v%0d_stat_mp", i), sm, e.sm);
      end
      @(posedge clk); #1;
      if (vecs[i].mem) begin
        exp_b++;
        if (vecs[i].mis) exp_m++;
      end
    end
    mem = 1'b0; mis = 1'b0; dec = 1'b0;

    // gshare: outcomes T,T,N,T into entry 0 (counter 1->2->3->2->3)
    g_dec = 1'b1; g_addr = 32'h8;
    @(negedge clk);
    chk("g_idx_reset", {28'b0, g_pidx}, 32'h2);
    @(posedge clk); #1;
    gseq = 4'b1011;  // bit0 first
    for (int i = 0; i < 4; i++) begin
      g_mem = 1'b1; g_uidx = 4'd0; g_act = gseq[i];
      @(posedge clk); #1;
    end
    g_mem = 1'b0;
    g_addr = 32'h8;
    @(negedge clk);
    chk("g_idx_hist", {28'b0, g_pidx}, 32'hF);
    chk("g_pred_hist", {31'b0, g_pred}, 32'h0);
    g_addr = 32'h34;
    @(negedge clk);
    chk("g_idx_zero", {28'b0, g_pidx}, 32'h0);
    chk("g_pred_trained", {31'b0, g_pred}, 32'h1);
    chk("g_stat_br", g_sb, 32'h4);
    @(posedge clk); #1;

    // Narrow statistics: 20 updates (7 mispredicted), then 3 ignored flags
    nb = 0; nm = 0;
    for (int i = 0; i < 23; i++) begin
      s_mem = (i < 20);
      s_mis = (i < 7) || (i >= 20);
      s_act = i[0];
      s_uidx = i[3:0];
      @(negedge clk);
      chk($sformatf("s%0d_br", i), {28'b0, s_sb}, (nb > 15) ? 32'd15 : 32'(nb));
      chk($sformatf("s%0d_mp", i), {28'b0, s_sm}, (nm > 15) ? 32'd15 : 32'(nm));
      @(posedge clk); #1;
      if (s_mem) begin
        nb++;
        if (s_mis) nm++;
      end
    end
    s_mem = 1'b0; s_mis = 1'b0;
    @(negedge clk);
    chk("s_final_br", {28'b0, s_sb}, 32'd15);
    chk("s_final_mp", {28'b0, s_sm}, 32'd7);
    @(posedge clk); #1;

    // Asynchronous reset of a trained entry (index 5 currently 1 -> train to 3)
    for (int i = 0; i < 2; i++) begin
      mem = 1'b1; act = 1'b1; uidx = 4'd5; mis = 1'b0;
      @(posedge clk); #1;
      exp_b++;
    end
    mem = 1'b0;
    dec = 1'b1; addr = 32'h14; off = 32'h0;
    @(negedge clk);
    chk("pre_rst_pred", {31'b0, pred}, 32'h1);
    chk("pre_rst_stat_br", sb, exp_b);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pred", {31'b0, pred}, 32'h0);
    chk("async_rst_idx", {28'b0, pidx}, 32'h5);
    chk("async_rst_stat_br", sb, 32'h0);
    chk("async_rst_stat_mp", sm, 32'h0);
    chk("async_rst_s_br", {28'b0, s_sb}, 32'h0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_pred", {31'b0, pred}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
